// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Purpose: Shared CPU definitions: default datapath widths, load funct3
//          encodings, write-back FSM state encoding and a misalignment helper.
// Ports  : none (package)
// Config : WB_MISALIGN_EN (consumed by wb_stage, not by this package)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int CPU_XLEN    = 32;
  localparam int CPU_RADDR_W = 5;

  // Load funct3 encodings; 011/110/111 fall through to word behaviour.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_t;

  // Signed halfword at an odd address, or any word-class load off a word
  // boundary. LHU is deliberately not flagged.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_LH:                  mis = addr_lo[0];
      F3_LB, F3_LBU, F3_LHU:  mis = 1'b0;
      default:                mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module : load_align
// Purpose: Combinational load data alignment and sign/zero extension.
// Ports  : data    in  XLEN  raw word-aligned memory data
//          funct3  in  3     load type
//          addr_lo in  2     effective address bits [1:0]
//          result  out XLEN  aligned, extended load value
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data[{addr_lo, 3'b000} +: 8];
  // Halfword selection only looks at addr_lo[1]; an odd address is the
  // caller's problem (flagged upstream when the misalign check is built in).
  assign half_sel = data[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    result = data;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module : wb_stage
// Purpose: Write-back stage feeding the register file write port. ALU results
//          are written one cycle after acceptance; loads park in WAIT_MEM until
//          the memory response, then write aligned/extended data.
// Ports  : i_clk, i_rst (async, active high)
//          i_ex_valid/o_ex_ready/i_ex_rd/i_ex_result/i_ex_load/i_ex_funct3/
//          i_ex_addr_lo : retiring instruction from execute
//          i_mem_valid/i_mem_data : load response
//          o_we/o_addr_wr/o_dat_wr : register file write port (registered)
//          o_pending/o_pending_rd  : outstanding load for hazard logic
//          o_misaligned            : misaligned-load pulse
// Config : WB_MISALIGN_EN - when defined, misaligned LH/LW suppress the write
//          and pulse o_misaligned instead; otherwise o_misaligned is 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = CPU_XLEN,
  parameter int RADDR_W = CPU_RADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ex_valid,
  output logic               o_ex_ready,
  input  logic [RADDR_W-1:0] i_ex_rd,
  input  logic [XLEN-1:0]    i_ex_result,
  input  logic               i_ex_load,
  input  logic [2:0]         i_ex_funct3,
  input  logic [1:0]         i_ex_addr_lo,
  input  logic               i_mem_valid,
  input  logic [XLEN-1:0]    i_mem_data,
  output logic               o_we,
  output logic [RADDR_W-1:0] o_addr_wr,
  output logic [XLEN-1:0]    o_dat_wr,
  output logic               o_pending,
  output logic [RADDR_W-1:0] o_pending_rd,
  output logic               o_misaligned
);

  wb_state_t   state;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_mis;
  logic        mis_detect;
  logic [XLEN-1:0] aligned;

  assign o_ex_ready = (state == ST_IDLE);

`ifdef WB_MISALIGN_EN
  assign mis_detect = is_misaligned(i_ex_funct3, i_ex_addr_lo);
`else
  assign mis_detect = 1'b0;
`endif

  load_align #(.XLEN(XLEN)) u_load_align (
    .data    (i_mem_data),
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .result  (aligned)
  );

  // o_pending_rd doubles as the destination register of the parked load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_we         <= 1'b0;
      o_addr_wr    <= '0;
      o_dat_wr     <= '0;
      o_pending    <= 1'b0;
      o_pending_rd <= '0;
      o_misaligned <= 1'b0;
      ld_funct3    <= 3'b000;
      ld_addr_lo   <= 2'b00;
      ld_mis       <= 1'b0;
    end else begin
      o_we         <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_ex_valid) begin
            if (i_ex_load) begin
              state        <= ST_WAIT_MEM;
              o_pending    <= 1'b1;
              o_pending_rd <= i_ex_rd;
              ld_funct3    <= i_ex_funct3;
              ld_addr_lo   <= i_ex_addr_lo;
              ld_mis       <= mis_detect;
            end else if (i_ex_rd != '0) begin
              o_we      <= 1'b1;
              o_addr_wr <= i_ex_rd;
              o_dat_wr  <= i_ex_result;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (i_mem_valid) begin
            state     <= ST_IDLE;
            o_pending <= 1'b0;
            if (ld_mis) begin
              o_misaligned <= 1'b1;
            end else if (o_pending_rd != '0) begin
              o_we      <= 1'b1;
              o_addr_wr <= o_pending_rd;
              o_dat_wr  <= aligned;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none

module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        we;
  logic [4:0]  addr_wr;
  logic [31:0] dat_wr;
  logic        pending;
  logic [4:0]  pending_rd;
  logic        misaligned;

  int checks = 0;
  int fails  = 0;

  wb_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ex_valid   (ex_valid),
    .o_ex_ready   (ex_ready),
    .i_ex_rd      (ex_rd),
    .i_ex_result  (ex_result),
    .i_ex_load    (ex_load),
    .i_ex_funct3  (ex_funct3),
    .i_ex_addr_lo (ex_addr_lo),
    .i_mem_valid  (mem_valid),
    .i_mem_data   (mem_data),
    .o_we         (we),
    .o_addr_wr    (addr_wr),
    .o_dat_wr     (dat_wr),
    .o_pending    (pending),
    .o_pending_rd (pending_rd),
    .o_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_rd = 5'd0; ex_result = 32'h0;
    ex_funct3 = 3'b000; ex_addr_lo = 2'b00; mem_valid = 1'b0; mem_data = 32'h0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    ex_valid = 1'b1; ex_load = 1'b1; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = lo;
    tick();
    ex_valid = 1'b0; ex_load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (addr_wr !== 5'd0) begin fails++; $display("FAIL reset_addr got=%0d exp=0", addr_wr); end
    checks++; if (dat_wr !== 32'h0) begin fails++; $display("FAIL reset_dat got=%h exp=0", dat_wr); end
    checks++; if (pending !== 1'b0 || pending_rd !== 5'd0) begin fails++; $display("FAIL reset_pending got=%b/%0d exp=0/0", pending, pending_rd); end
    checks++; if (misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
    checks++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'hDEADBEEF;
    tick();
    ex_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd5 || dat_wr !== 32'hDEADBEEF) begin
      fails++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", we, addr_wr, dat_wr); end
    tick();
    checks++; if (we !== 1'b0 || dat_wr !== 32'hDEADBEEF) begin
      fails++; $display("FAIL alu_pulse_hold got=%b/%h exp=0/deadbeef", we, dat_wr); end
    // rd=0 ALU op: no write, port holds
    ex_valid = 1'b1; ex_rd = 5'd0; ex_result = 32'h12345678;
    tick();
    ex_valid = 1'b0;
    checks++; if (we !== 1'b0 || addr_wr !== 5'd5 || dat_wr !== 32'hDEADBEEF) begin
      fails++; $display("FAIL alu_x0 got=%b/%0d/%h exp=0/5/deadbeef", we, addr_wr, dat_wr); end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; ex_rd = 5'd1; ex_result = 32'h0000_0011;
    tick();
    checks++; if (we !== 1'b1 || addr_wr !== 5'd1 || dat_wr !== 32'h11 || ex_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_first got=%b/%0d/%h rdy=%b exp=1/1/11 rdy=1", we, addr_wr, dat_wr, ex_ready); end
    ex_rd = 5'd2; ex_result = 32'h0000_0022;
    tick();
    ex_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd2 || dat_wr !== 32'h22) begin
      fails++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/2/22", we, addr_wr, dat_wr); end
    tick();
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL b2b_end got=%b exp=0", we); end
  endtask

  task automatic test_lb();
    issue_load(5'd3, 3'b000, 2'd2);
    checks++; if (pending !== 1'b1 || pending_rd !== 5'd3 || ex_ready !== 1'b0 || we !== 1'b0) begin
      fails++; $display("FAIL lb_wait got=p%b/%0d rdy=%b we=%b exp=p1/3 rdy=0 we=0", pending, pending_rd, ex_ready, we); end
    tick();
    checks++; if (ex_ready !== 1'b0 || pending !== 1'b1) begin
      fails++; $display("FAIL lb_still_wait got=rdy%b p%b exp=rdy0 p1", ex_ready, pending); end
    mem_valid = 1'b1; mem_data = 32'h0080_0000;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd3 || dat_wr !== 32'hFFFFFF80) begin
      fails++; $display("FAIL lb_data got=%b/%0d/%h exp=1/3/ffffff80", we, addr_wr, dat_wr); end
    checks++; if (pending !== 1'b0 || ex_ready !== 1'b1) begin
      fails++; $display("FAIL lb_done got=p%b rdy%b exp=p0 rdy1", pending, ex_ready); end
  endtask

  task automatic test_lhu_bubble();
    issue_load(5'd4, 3'b101, 2'd2);
    // ALU op presented while the response arrives must not be accepted then
    ex_valid = 1'b1; ex_rd = 5'd10; ex_result = 32'h0000_00AA;
    mem_valid = 1'b1; mem_data = 32'h8001_0000;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd4 || dat_wr !== 32'h0000_8001) begin
      fails++; $display("FAIL lhu_data got=%b/%0d/%h exp=1/4/00008001", we, addr_wr, dat_wr); end
    tick();
    ex_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd10 || dat_wr !== 32'hAA) begin
      fails++; $display("FAIL bubble_alu got=%b/%0d/%h exp=1/10/aa", we, addr_wr, dat_wr); end
    tick();
  endtask

  task automatic test_lh_lb_variants();
    issue_load(5'd7, 3'b001, 2'd0);
    mem_valid = 1'b1; mem_data = 32'h1234_8001;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd7 || dat_wr !== 32'hFFFF8001) begin
      fails++; $display("FAIL lh_sext got=%b/%0d/%h exp=1/7/ffff8001", we, addr_wr, dat_wr); end
    issue_load(5'd8, 3'b100, 2'd3);
    mem_valid = 1'b1; mem_data = 32'hF100_0000;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b1 || addr_wr !== 5'd8 || dat_wr !== 32'h0000_00F1) begin
      fails++; $display("FAIL lbu_zext got=%b/%0d/%h exp=1/8/000000f1", we, addr_wr, dat_wr); end
  endtask

  task automatic test_lw_x0();
    issue_load(5'd0, 3'b010, 2'd0);
    checks++; if (pending !== 1'b1 || pending_rd !== 5'd0) begin
      fails++; $display("FAIL lw_x0_wait got=p%b/%0d exp=p1/0", pending, pending_rd); end
    mem_valid = 1'b1; mem_data = 32'h5555_5555;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b0 || pending !== 1'b0 || ex_ready !== 1'b1 || dat_wr !== 32'h0000_00F1) begin
      fails++; $display("FAIL lw_x0_done got=we%b p%b rdy%b dat=%h exp=we0 p0 rdy1 dat=000000f1", we, pending, ex_ready, dat_wr); end
  endtask

  task automatic test_misaligned();
    issue_load(5'd6, 3'b010, 2'd1);
    mem_valid = 1'b1; mem_data = 32'hCAFE_F00D;
    tick();
    mem_valid = 1'b0;
`ifdef WB_MISALIGN_EN
    checks++; if (misaligned !== 1'b1 || we !== 1'b0 || pending !== 1'b0) begin
      fails++; $display("FAIL mis_pulse got=mis%b we%b p%b exp=mis1 we0 p0", misaligned, we, pending); end
    tick();
    checks++; if (misaligned !== 1'b0) begin fails++; $display("FAIL mis_one_cycle got=%b exp=0", misaligned); end
`else
    checks++; if (misaligned !== 1'b0 || we !== 1'b1 || addr_wr !== 5'd6 || dat_wr !== 32'hCAFEF00D) begin
      fails++; $display("FAIL mis_off_write got=mis%b %b/%0d/%h exp=mis0 1/6/cafef00d", misaligned, we, addr_wr, dat_wr); end
    tick();
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL mis_off_pulse got=%b exp=0", we); end
`endif
  endtask

  task automatic test_idle_mem_valid();
    mem_valid = 1'b1; mem_data = 32'hFFFF_FFFF;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b0 || misaligned !== 1'b0 || ex_ready !== 1'b1) begin
      fails++; $display("FAIL idle_mem got=we%b mis%b rdy%b exp=we0 mis0 rdy1", we, misaligned, ex_ready); end
  endtask

  task automatic test_reset_midload();
    issue_load(5'd9, 3'b010, 2'd0);
    checks++; if (pending !== 1'b1 || pending_rd !== 5'd9) begin
      fails++; $display("FAIL midrst_wait got=p%b/%0d exp=p1/9", pending, pending_rd); end
    rst = 1'b1;
    #1;
    checks++; if (pending !== 1'b0 || ex_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_async got=p%b rdy%b exp=p0 rdy1", pending, ex_ready); end
    tick();
    rst = 1'b0;
    tick();
    mem_valid = 1'b1; mem_data = 32'h1111_1111;
    tick();
    mem_valid = 1'b0;
    checks++; if (we !== 1'b0 || pending !== 1'b0 || ex_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_ignore got=we%b p%b rdy%b exp=we0 p0 rdy1", we, pending, ex_ready); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_back_to_back();
    test_lb();
    test_lhu_bubble();
    test_lh_lb_variants();
    test_lw_x0();
    test_misaligned();
    test_idle_mem_valid();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
